mdu_iterative: RTL and testbench

MDU_ITERATIVE -- requirements
Module: mdu_iterative

---
 rtl/mdu_iterative.sv | 191 +++++++++++++++++++
 tb/tb_mdu_iterative.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_iterative.sv
// rtl/mdu_iterative.sv - iterative RV32M multiply/divide unit (32 cycles per op)
//
// Ports:
//   CLK     in   1   clock, rising edge
//   RESET   in   1   asynchronous active-low reset
//   START   in   1   M-extension op valid, sampled only in IDLE
//   KILL    in   1   synchronous abort back to IDLE
//   FUNC3   in   3   op select (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   DATA1   in  32   operand rs1
//   DATA2   in  32   operand rs2
//   RESULT  out 32   registered result, held until the next DONE
//   DONE    out  1   one-cycle result-valid pulse
//   BUSY    out  1   pipeline stall request

module mdu_iterative (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic        KILL,
    input  logic [2:0]  FUNC3,
    input  logic [31:0] DATA1,
    input  logic [31:0] DATA2,
    output logic [31:0] RESULT,
    output logic        DONE,
    output logic        BUSY
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic [2:0]  func_q;
    logic [31:0] op_b;       // multiplicand magnitude (mul) or divisor magnitude (div)
    logic [31:0] acc_hi;     // product high half (mul) or partial remainder (div)
    logic [31:0] acc_lo;     // multiplier/product low half (mul) or dividend/quotient (div)
    logic        neg_q;      // product or quotient must be negated in FIX
    logic        rem_neg_q;  // remainder takes the dividend sign

    // Operand decode on the live inputs, used only when an op is accepted.
    logic        is_div;
    logic        a_signed;
    logic        b_signed;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic        div_zero;
    logic        div_ovf;
    logic        special;
    logic [31:0] special_result;

    always_comb begin
        is_div   = FUNC3[2];
        a_signed = is_div ? ~FUNC3[0] : (FUNC3 == 3'b001 || FUNC3 == 3'b010);
        b_signed = is_div ? ~FUNC3[0] : (FUNC3 == 3'b001);
        a_neg    = a_signed & DATA1[31];
        b_neg    = b_signed & DATA2[31];
        a_mag    = a_neg ? (~DATA1 + 32'd1) : DATA1;
        b_mag    = b_neg ? (~DATA2 + 32'd1) : DATA2;
        div_zero = is_div && (DATA2 == 32'd0);
        div_ovf  = is_div && !FUNC3[0] && (DATA1 == 32'h8000_0000) && (DATA2 == 32'hFFFF_FFFF);
        special  = div_zero | div_ovf;
        // FUNC3[1] separates REM/REMU from DIV/DIVU.
        if (div_zero) begin
            special_result = FUNC3[1] ? DATA1 : 32'hFFFF_FFFF;
        end else begin
            special_result = FUNC3[1] ? 32'd0 : 32'h8000_0000;
        end
    end

    // One iteration of each datapath.
    logic [32:0] mul_sum;
    logic [32:0] div_trial;
    logic        div_ok;

    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, op_b} : 33'd0);
        // Shifted remainder is below 2*divisor, so bit 32 is a clean borrow flag.
        div_trial = {acc_hi, acc_lo[31]} - {1'b0, op_b};
        div_ok    = ~div_trial[32];
    end

    // Sign correction and result selection.
    logic [63:0] product;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    logic [31:0] fix_result;

    always_comb begin
        product  = {acc_hi, acc_lo};
        prod_fix = neg_q ? (~product + 64'd1) : product;
        quo_fix  = neg_q ? (~acc_lo + 32'd1) : acc_lo;
        rem_fix  = rem_neg_q ? (~acc_hi + 32'd1) : acc_hi;
        case (func_q)
            3'b000:                 fix_result = prod_fix[31:0];
            3'b001, 3'b010, 3'b011: fix_result = prod_fix[63:32];
            3'b100, 3'b101:         fix_result = quo_fix;
            default:                fix_result = rem_fix;
        endcase
    end

    always_comb begin
        BUSY = 1'b0;
        if (RESET) begin
            if (state == S_CALC || state == S_FIX) begin
                BUSY = 1'b1;
            end else if (state == S_IDLE && START && !KILL && !special) begin
                BUSY = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state     <= S_IDLE;
            cnt       <= 5'd0;
            func_q    <= 3'd0;
            op_b      <= 32'd0;
            acc_hi    <= 32'd0;
            acc_lo    <= 32'd0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            RESULT    <= 32'd0;
            DONE      <= 1'b0;
        end else if (KILL) begin
            state <= S_IDLE;
            cnt   <= 5'd0;
            DONE  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    DONE <= 1'b0;
                    if (START) begin
                        func_q    <= FUNC3;
                        neg_q     <= a_neg ^ b_neg;
                        rem_neg_q <= a_neg;
                        cnt       <= 5'd0;
                        acc_hi    <= 32'd0;
                        if (is_div) begin
                            acc_lo <= a_mag;
                            op_b   <= b_mag;
                        end else begin
                            acc_lo <= b_mag;
                            op_b   <= a_mag;
                        end
                        if (special) begin
                            RESULT <= special_result;
                            DONE   <= 1'b1;
                            state  <= S_DONE;
                        end else begin
                            state  <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (func_q[2]) begin
                        acc_hi <= div_ok ? div_trial[31:0] : {acc_hi[30:0], acc_lo[31]};
                        acc_lo <= {acc_lo[30:0], div_ok};
                    end else begin
                        acc_hi <= mul_sum[32:1];
                        acc_lo <= {mul_sum[0], acc_lo[31:1]};
                    end
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    RESULT <= fix_result;
                    DONE   <= 1'b1;
                    state  <= S_DONE;
                end
                S_DONE: begin
                    DONE  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    DONE  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_iterative.sv
// tb/tb_mdu_iterative.sv - scoreboard testbench for mdu_iterative

module tb_mdu_iterative;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        START;
    logic        KILL;
    logic [2:0]  FUNC3;
    logic [31:0] DATA1;
    logic [31:0] DATA2;
    logic [31:0] RESULT;
    logic        DONE;
    logic        BUSY;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          done_cnt = 0;
    logic [31:0] exp_q[$];

    mdu_iterative dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .START  (START),
        .KILL   (KILL),
        .FUNC3  (FUNC3),
        .DATA1  (DATA1),
        .DATA2  (DATA2),
        .RESULT (RESULT),
        .DONE   (DONE),
        .BUSY   (BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sp;
        logic [63:0]        up;
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic signed [31:0] sr;
        logic               ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin up = {32'd0, a} * {32'd0, b}; return up[31:0]; end
            3'd1: begin sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return sp[63:32]; end
            3'd2: begin sp = $signed({{32{a[31]}}, a}) * $signed({32'd0, b}); return sp[63:32]; end
            3'd3: begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                sr = sa / sb;
                return sr;
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (ovf) return 32'd0;
                sr = sa % sb;
                return sr;
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return f[2] && ((b == 32'd0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    // Scoreboard: every DONE pulse pops one expected result.
    always @(negedge CLK) begin
        if (RESET === 1'b1 && DONE === 1'b1) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                check("spurious_done", 32'(exp_q.size()), 32'd1);
            end else begin
                check("result", RESULT, exp_q.pop_front());
            end
        end
    end

    // Waits for DONE from just after the accepting edge; returns cycles waited.
    task automatic wait_done(output int lat, output bit busy_bad);
        lat      = 0;
        busy_bad = 1'b0;
        while (DONE !== 1'b1 && lat < 100) begin
            if (BUSY !== 1'b1) busy_bad = 1'b1;
            tick();
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        int lat;
        bit busy_bad;
        bit sp;
        int d0;
        sp = is_special(f, a, b);
        d0 = done_cnt;
        exp_q.push_back(exp);
        FUNC3 = f;
        DATA1 = a;
        DATA2 = b;
        START = 1'b1;
        #1;
        check({tag, "_busy_start"}, 32'(BUSY), sp ? 32'd0 : 32'd1);
        tick();
        // Scramble inputs: the op in flight must not see them.
        START = 1'b0;
        FUNC3 = 3'($urandom);
        DATA1 = $urandom;
        DATA2 = $urandom;
        wait_done(lat, busy_bad);
        check({tag, "_latency"}, 32'(lat), sp ? 32'd0 : 32'd33);
        check({tag, "_busy_calc"}, 32'(busy_bad), 32'd0);
        check({tag, "_busy_done"}, 32'(BUSY), 32'd0);
        tick();
        check({tag, "_done_width"}, 32'(DONE), 32'd0);
        check({tag, "_done_count"}, 32'(done_cnt - d0), 32'd1);
        check({tag, "_result_hold"}, RESULT, exp);
    endtask

    initial begin
        int          lat;
        bit          busy_bad;
        int          d0;
        logic [31:0] r0;
        logic [2:0]  rf;
        logic [31:0] ra;
        logic [31:0] rb;

        RESET = 1'b0;
        START = 1'b1;
        KILL  = 1'b0;
        FUNC3 = 3'd0;
        DATA1 = 32'd5;
        DATA2 = 32'd1;
        #12;
        check("reset_result", RESULT, 32'd0);
        check("reset_done", 32'(DONE), 32'd0);
        check("reset_busy", 32'(BUSY), 32'd0);
        START = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
        tick();

        run_op("mul_neg", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        run_op("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        run_op("mulhu_min", 3'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);
        run_op("div_neg", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run_op("rem_neg", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run_op("divu", 3'd5, 32'd100, 32'd7, 32'd14);
        run_op("divu_zero", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF);
        run_op("rem_zero", 3'd6, 32'd5, 32'd0, 32'd5);
        run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        run_op("div_zero", 3'd4, 32'hDEAD_BEEF, 32'd0, 32'hFFFF_FFFF);
        run_op("divu_big", 3'd5, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF);

        for (int i = 0; i < 24; i++) begin
            rf = 3'($urandom);
            ra = $urandom;
            rb = (i % 6 == 0) ? 32'd0 : ((i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom);
            run_op("rand", rf, ra, rb, model(rf, ra, rb));
        end

        // START held high with new operands through the whole op.
        exp_q.push_back(model(3'd0, 32'h1234, 32'h5678));
        FUNC3 = 3'd0;
        DATA1 = 32'h1234;
        DATA2 = 32'h5678;
        START = 1'b1;
        tick();
        FUNC3 = 3'd5;
        DATA1 = 32'd1000;
        DATA2 = 32'd33;
        wait_done(lat, busy_bad);
        check("hold_latency", 32'(lat), 32'd33);
        check("hold_busy_done", 32'(BUSY), 32'd0);
        exp_q.push_back(model(3'd5, 32'd1000, 32'd33));
        tick();
        check("hold_reaccept_busy", 32'(BUSY), 32'd1);
        tick();
        START = 1'b0;
        wait_done(lat, busy_bad);
        check("hold2_latency", 32'(lat), 32'd33);
        tick();
        check("hold2_result", RESULT, 32'd30);

        // KILL at CALC iteration 5.
        d0 = done_cnt;
        r0 = RESULT;
        FUNC3 = 3'd0;
        DATA1 = 32'd9;
        DATA2 = 32'd9;
        START = 1'b1;
        tick();
        START = 1'b0;
        repeat (5) tick();
        KILL = 1'b1;
        tick();
        KILL = 1'b0;
        #1;
        check("kill_busy", 32'(BUSY), 32'd0);
        repeat (40) tick();
        check("kill_no_done", 32'(done_cnt - d0), 32'd0);
        check("kill_result", RESULT, r0);

        // KILL beats START in IDLE.
        START = 1'b1;
        KILL  = 1'b1;
        #1;
        check("kill_prio_busy", 32'(BUSY), 32'd0);
        tick();
        START = 1'b0;
        KILL  = 1'b0;
        #1;
        check("kill_prio_idle", 32'(BUSY), 32'd0);
        repeat (40) tick();
        check("kill_prio_no_done", 32'(done_cnt - d0), 32'd0);

        // Asynchronous reset at CALC iteration 10.
        START = 1'b1;
        FUNC3 = 3'd0;
        DATA1 = 32'h1234;
        DATA2 = 32'h10;
        tick();
        START = 1'b0;
        repeat (10) tick();
        #2;
        RESET = 1'b0;
        #1;
        check("rst_mid_result", RESULT, 32'd0);
        check("rst_mid_busy", 32'(BUSY), 32'd0);
        check("rst_mid_done", 32'(DONE), 32'd0);
        repeat (2) tick();
        @(negedge CLK);
        RESET = 1'b1;
        tick();
        check("rst_no_done", 32'(done_cnt - d0), 32'd0);
        run_op("mul_after_rst", 3'd0, 32'd3, 32'd4, 32'd12);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
